// File: rtl/torq_calc_mc.sv
// torq_calc_mc: multi-channel Iq*Kt torque stream with round/saturate, optional
// per-channel averaging and a credit-controlled first-word-fall-through output FIFO.
module torq_calc_mc #(
   parameter int DATA_W     = 16,
   parameter int COEF_W     = 18,
   parameter int FRAC_BITS  = 15,
   parameter int OUT_W      = 16,
   parameter int NUM_CH     = 4,
   parameter int AVG_LOG2   = 2,
   parameter int FIFO_DEPTH = 8,
   localparam int CH_W      = $clog2(NUM_CH)
) (
   input  logic                     aclk,
   input  logic                     areset,
   input  logic                     cfg_we,
   input  logic [CH_W-1:0]          cfg_ch,
   input  logic signed [COEF_W-1:0] cfg_kt,
   input  logic                     cfg_avg_en,
   input  logic                     sat_clr,
   input  logic                     s_axis_tvalid,
   output logic                     s_axis_tready,
   input  logic signed [DATA_W-1:0] s_axis_tdata,
   input  logic [CH_W-1:0]          s_axis_tuser,
   input  logic                     s_axis_tlast,
   output logic                     m_axis_tvalid,
   input  logic                     m_axis_tready,
   output logic signed [OUT_W-1:0]  m_axis_tdata,
   output logic [CH_W-1:0]          m_axis_tuser,
   output logic                     m_axis_tlast,
   output logic                     sat_flag,
   output logic                     ch_err
);
   localparam int PW = DATA_W + COEF_W;
   localparam int AW = OUT_W + AVG_LOG2;
   localparam int FA = $clog2(FIFO_DEPTH);
   localparam int EW = OUT_W + CH_W + 1;
   localparam logic signed [PW:0] MAXV = (PW+1)'(2**(OUT_W-1) - 1);
   localparam logic signed [PW:0] MINV = -MAXV - 1;

   logic signed [COEF_W-1:0] kt [NUM_CH];
   logic signed [AW-1:0]     acc [NUM_CH];
   logic [AVG_LOG2-1:0]      cnt [NUM_CH];
   logic [NUM_CH-1:0]        lor;
   logic [EW-1:0]            mem [FIFO_DEPTH];
   logic [FA-1:0]            wp, rp;
   logic [FA:0]              fcnt, fcnt_n;
   logic [1:0]               infl_n;
   logic                     v1, v2, v3, l1, l2, l3, avg3, avg_q, rdy;
   logic [CH_W-1:0]          c1, c2, c3;
   logic signed [DATA_W-1:0] iq1;
   logic signed [COEF_W-1:0] kt1;
   logic signed [PW-1:0]     p2;
   logic signed [PW:0]       pr, rs;
   logic signed [OUT_W-1:0]  r2, r3;
   logic signed [AW-1:0]     sum, avg_sh;
   logic                     take, ok_ch, v1_n, hi, lo, fin, push, pop, tog, rdy_n;
   logic [EW-1:0]            din;

   assign take   = s_axis_tvalid && s_axis_tready;
   assign ok_ch  = int'(s_axis_tuser) < NUM_CH;
   assign v1_n   = take && ok_ch;
   assign pr     = $signed({p2[PW-1], p2}) + (PW+1)'(2**(FRAC_BITS-1));
   assign rs     = pr >>> FRAC_BITS;
   assign hi     = rs > MAXV;
   assign lo     = rs < MINV;
   assign r2     = hi ? MAXV[OUT_W-1:0] : lo ? MINV[OUT_W-1:0] : rs[OUT_W-1:0];
   // The last sample of a window is the one that finds the count saturated at all ones.
   assign fin    = avg3 && cnt[c3] == '1;
   assign sum    = acc[c3] + AW'(r3);
   assign avg_sh = sum >>> AVG_LOG2;
   assign push   = v3 && (!avg3 || fin);
   assign pop    = m_axis_tvalid && m_axis_tready;
   assign din    = {avg3 ? avg_sh[OUT_W-1:0] : r3, c3, avg3 ? (lor[c3] | l3) : l3};
   assign tog    = cfg_avg_en ^ avg_q;
   assign fcnt_n = fcnt + (FA+1)'(push) - (FA+1)'(pop);
   assign infl_n = 2'(v1_n) + 2'(v1) + 2'(v2);
   // Every in-flight sample holds a FIFO slot, so the FIFO can never overflow.
   assign rdy_n  = (FA+2)'(fcnt_n) + (FA+2)'(infl_n) < (FA+2)'(FIFO_DEPTH);

   assign s_axis_tready = rdy;
   assign m_axis_tvalid = fcnt != '0;
   assign {m_axis_tdata, m_axis_tuser, m_axis_tlast} = m_axis_tvalid ? mem[rp] : '0;

   always_ff @(posedge aclk or posedge areset)
      if (areset) begin
         rdy <= 1'b0;
         {v1, v2, v3, l1, l2, l3, avg3, avg_q, sat_flag, ch_err} <= '0;
         {c1, c2, c3, iq1, kt1, p2, r3, wp, rp, fcnt, lor} <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            kt[i]  <= '0;
            acc[i] <= '0;
            cnt[i] <= '0;
         end
      end else begin
         rdy <= rdy_n;
         if (cfg_we && int'(cfg_ch) < NUM_CH) kt[cfg_ch] <= cfg_kt;
         v1 <= v1_n;
         if (v1_n) begin
            iq1 <= s_axis_tdata;
            kt1 <= kt[s_axis_tuser];
            c1  <= s_axis_tuser;
            l1  <= s_axis_tlast;
         end
         v2 <= v1;
         p2 <= PW'(iq1) * PW'(kt1);
         c2 <= c1;
         l2 <= l1;
         v3 <= v2;
         r3 <= r2;
         c3 <= c2;
         l3 <= l2;
         avg3 <= cfg_avg_en;
         avg_q <= cfg_avg_en;
         sat_flag <= (sat_flag && !sat_clr) || (v2 && (hi || lo));
         ch_err <= (ch_err && !sat_clr) || (take && !ok_ch);
         if (tog) begin
            lor <= '0;
            for (int i = 0; i < NUM_CH; i++) begin
               acc[i] <= '0;
               cnt[i] <= '0;
            end
         end else if (v3 && avg3) begin
            acc[c3] <= fin ? '0 : sum;
            cnt[c3] <= cnt[c3] + AVG_LOG2'(1);
            lor[c3] <= !fin && (lor[c3] || l3);
         end
         if (push) wp <= wp + FA'(1);
         if (pop) rp <= rp + FA'(1);
         fcnt <= fcnt_n;
      end

   always_ff @(posedge aclk)
      if (push) mem[wp] <= din;
endmodule
